// File: rtl/csr_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// csr_access_unit_pkg
// Shared constants for the CSR access unit: Zicsr operation encodings, the FSM
// state encoding, and the address field value that marks a read-only CSR
// (address bits [11:10] == 2'b11).
// -----------------------------------------------------------------------------
package csr_access_unit_pkg;

  localparam logic [1:0] CSR_OP_RSV = 2'b00;
  localparam logic [1:0] CSR_OP_RW  = 2'b01;
  localparam logic [1:0] CSR_OP_RS  = 2'b10;
  localparam logic [1:0] CSR_OP_RC  = 2'b11;

  // Top two address bits of a read-only CSR.
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/csr_access_unit_rmw_alu.sv
// -----------------------------------------------------------------------------
// csr_rmw_alu
// Combinational read-modify-write value for Zicsr instructions.
//   op_i      : operation (RW / RS / RC)
//   old_i     : old CSR value (0 when the CSR was not read)
//   operand_i : rs1 value or zero-extended immediate
//   new_o     : value to be written back to the CSR
// -----------------------------------------------------------------------------
module csr_rmw_alu
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = old_i;
    case (op_i)
      CSR_OP_RW: new_o = operand_i;
      CSR_OP_RS: new_o = old_i | operand_i;
      CSR_OP_RC: new_o = old_i & ~operand_i;
      default:   new_o = old_i;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// -----------------------------------------------------------------------------
// csr_access_unit
// Initiator side of the CSR port. Accepts one decoded Zicsr request at a time,
// performs the read-modify-write sequence against the CSR file and returns the
// old CSR value for writeback to rd.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_*                    : request handshake and decoded fields
//   csr_rd_* / csr_wr_*      : read / write channels to the CSR file
//   rsp_*                    : result handshake towards writeback
//
// Build option:
//   CSR_RO_CHECK_EN : when defined, a writing request to a read-only CSR
//                     (address [11:10] == 2'b11) is rejected as illegal
//                     without any CSR access.
// -----------------------------------------------------------------------------
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic                  req_imm,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]       req_rs1_val,
  input  logic [4:0]            req_zimm,
  input  logic [4:0]            req_rd_idx,
  output logic                  csr_rd_en,
  output logic [CSR_ADDR_W-1:0] csr_rd_addr,
  input  logic [XLEN-1:0]       csr_rd_data,
  input  logic                  csr_rd_valid,
  output logic                  csr_wr_en,
  output logic [CSR_ADDR_W-1:0] csr_wr_addr,
  output logic [XLEN-1:0]       csr_wr_data,
  input  logic                  csr_wr_ack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd_idx,
  output logic [XLEN-1:0]       rsp_rd_data,
  output logic                  rsp_illegal
);

  state_e state_q, state_d;
  logic   do_write_q, do_write_d;
  logic   illegal_q, illegal_d;

  logic [1:0]            op_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       operand_q;
  logic [4:0]            rd_idx_q;
  logic [XLEN-1:0]       old_q;

  logic [XLEN-1:0] operand_w;
  logic [XLEN-1:0] new_w;
  logic            do_read_w;
  logic            do_write_w;
  logic            ro_hit_w;
  logic            accept_w;

  // req_zimm is the immediate for the I-forms and the rs1 index otherwise, so
  // a zero value suppresses the write of RS/RC in both cases.
  assign operand_w  = req_imm ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_val;
  assign do_read_w  = !((req_op == CSR_OP_RW) && (req_rd_idx == 5'd0));
  assign do_write_w = (req_op == CSR_OP_RW) || (req_zimm != 5'd0);
  assign accept_w   = req_valid && (state_q == ST_IDLE);

`ifdef CSR_RO_CHECK_EN
  assign ro_hit_w = do_write_w && (req_addr[CSR_ADDR_W-1 -: 2] == CSR_RO_FIELD);
`else
  assign ro_hit_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      do_write_q <= do_write_d;
      illegal_q  <= illegal_d;
    end
  end

  // Datapath capture needs no reset: every output that exposes it is gated by
  // the state, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (accept_w) begin
      op_q      <= req_op;
      addr_q    <= req_addr;
      operand_q <= operand_w;
      rd_idx_q  <= req_rd_idx;
      old_q     <= '0;
    end else if ((state_q == ST_READ) && csr_rd_valid) begin
      old_q     <= csr_rd_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    do_write_d = do_write_q;
    illegal_d  = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          do_write_d = do_write_w;
          illegal_d  = 1'b0;
          if ((req_op == CSR_OP_RSV) || ro_hit_w) begin
            state_d   = ST_RESP;
            illegal_d = 1'b1;
          end else if (do_read_w) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (csr_rd_valid) begin
          state_d = do_write_q ? ST_WRITE : ST_RESP;
        end
      end
      ST_WRITE: begin
        if (csr_wr_ack) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  csr_rmw_alu #(
    .XLEN (XLEN)
  ) u_rmw_alu (
    .op_i      (op_q),
    .old_i     (old_q),
    .operand_i (operand_q),
    .new_o     (new_w)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign csr_rd_en   = (state_q == ST_READ);
  assign csr_rd_addr = csr_rd_en ? addr_q : '0;
  assign csr_wr_en   = (state_q == ST_WRITE);
  assign csr_wr_addr = csr_wr_en ? addr_q : '0;
  assign csr_wr_data = csr_wr_en ? new_w : '0;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rd_idx  = rsp_valid ? rd_idx_q : 5'd0;
  assign rsp_rd_data = rsp_valid ? old_q : '0;
  assign rsp_illegal = rsp_valid && illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_access_unit
// Directed bench for csr_access_unit. The CSR file is played by the tasks,
// cycle by cycle. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_csr_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_imm;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_zimm;
  logic [4:0]  req_rd_idx;
  logic        csr_rd_en;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_valid;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        csr_wr_ack;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_rd_data;
  logic        rsp_illegal;

  int errors = 0;
  int checks = 0;

  csr_access_unit #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_imm      (req_imm),
    .req_addr     (req_addr),
    .req_rs1_val  (req_rs1_val),
    .req_zimm     (req_zimm),
    .req_rd_idx   (req_rd_idx),
    .csr_rd_en    (csr_rd_en),
    .csr_rd_addr  (csr_rd_addr),
    .csr_rd_data  (csr_rd_data),
    .csr_rd_valid (csr_rd_valid),
    .csr_wr_en    (csr_wr_en),
    .csr_wr_addr  (csr_wr_addr),
    .csr_wr_data  (csr_wr_data),
    .csr_wr_ack   (csr_wr_ack),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rd_idx   (rsp_rd_idx),
    .rsp_rd_data  (rsp_rd_data),
    .rsp_illegal  (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] zimm, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_imm = imm; req_addr = addr;
    req_rs1_val = rs1; req_zimm = zimm; req_rd_idx = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    checks++; if (csr_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", csr_rd_en); end
    checks++; if (csr_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", csr_wr_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_rsp_illegal: got %b required 0", rsp_illegal); end
    checks++; if ({csr_rd_addr, csr_wr_addr, csr_wr_data, rsp_rd_data, rsp_rd_idx} !== '0) begin
      errors++; $display("FAIL reset_data_outputs: got %h required 0", {csr_rd_addr, csr_wr_addr, csr_wr_data, rsp_rd_data, rsp_rd_idx});
    end
    rst = 1'b0;
  endtask

  task automatic test_csrrw();
    set_req(2'b01, 1'b0, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b required 1", req_ready); end
    tick(); req_valid = 1'b0;
    checks++; if (csr_rd_en !== 1'b1 || csr_rd_addr !== 12'h340) begin errors++; $display("FAIL rw_read: got en=%b addr=%h required en=1 addr=340", csr_rd_en, csr_rd_addr); end
    checks++; if (req_ready !== 1'b0 || csr_wr_en !== 1'b0) begin errors++; $display("FAIL rw_busy: got ready=%b wr_en=%b required 0 0", req_ready, csr_wr_en); end
    csr_rd_data = 32'h12345678; csr_rd_valid = 1'b1;
    tick(); csr_rd_valid = 1'b0;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_addr !== 12'h340 || csr_wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rw_write: got en=%b addr=%h data=%h required 1 340 deadbeef", csr_wr_en, csr_wr_addr, csr_wr_data);
    end
    checks++; if (csr_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_write_only: got rd_en=%b rsp_valid=%b required 0 0", csr_rd_en, rsp_valid); end
    csr_wr_ack = 1'b1;
    tick(); csr_wr_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h12345678 || rsp_rd_idx !== 5'd5 || rsp_illegal !== 1'b0) begin
      errors++; $display("FAIL rw_resp_T3: got v=%b data=%h idx=%0d ill=%b required 1 12345678 5 0", rsp_valid, rsp_rd_data, rsp_rd_idx, rsp_illegal);
    end
    checks++; if (csr_wr_en !== 1'b0) begin errors++; $display("FAIL rw_wr_drop: got %b required 0", csr_wr_en); end
    tick();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_idle: got ready=%b v=%b required 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_csrrs_noread_write();
    // rs1 index 0: read only, rs1 value must be ignored
    set_req(2'b10, 1'b0, 12'h300, 32'hFFFFFFFF, 5'd0, 5'd3);
    tick(); req_valid = 1'b0;
    checks++; if (csr_rd_en !== 1'b1 || csr_rd_addr !== 12'h300) begin errors++; $display("FAIL rs0_read: got en=%b addr=%h required 1 300", csr_rd_en, csr_rd_addr); end
    csr_rd_data = 32'h00000088; csr_rd_valid = 1'b1;
    tick(); csr_rd_valid = 1'b0;
    checks++; if (csr_wr_en !== 1'b0) begin errors++; $display("FAIL rs0_no_write: got %b required 0", csr_wr_en); end
    checks++; if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h88 || rsp_rd_idx !== 5'd3) begin
      errors++; $display("FAIL rs0_resp: got v=%b data=%h idx=%0d required 1 88 3", rsp_valid, rsp_rd_data, rsp_rd_idx);
    end
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rs0_idle: got %b required 1", req_ready); end
  endtask

  task automatic test_csrrc_delayed();
    set_req(2'b11, 1'b0, 12'h344, 32'h0000000F, 5'd7, 5'd8);
    tick(); req_valid = 1'b0;
    csr_wr_ack = 1'b1; // stray ack during READ must be ignored
    for (int i = 0; i < 3; i++) begin
      checks++; if (csr_rd_en !== 1'b1 || csr_wr_en !== 1'b0) begin errors++; $display("FAIL rc_hold_%0d: got rd_en=%b wr_en=%b required 1 0", i, csr_rd_en, csr_wr_en); end
      if (i == 2) begin csr_rd_data = 32'h000000FF; csr_rd_valid = 1'b1; end
      tick();
      csr_wr_ack = 1'b0;
    end
    csr_rd_valid = 1'b0;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_data !== 32'h000000F0 || csr_wr_addr !== 12'h344) begin
      errors++; $display("FAIL rc_write: got en=%b data=%h addr=%h required 1 f0 344", csr_wr_en, csr_wr_data, csr_wr_addr);
    end
    tick();
    checks++; if (csr_wr_en !== 1'b1) begin errors++; $display("FAIL rc_wr_hold: got %b required 1", csr_wr_en); end
    csr_wr_ack = 1'b1;
    tick(); csr_wr_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'hFF || rsp_rd_idx !== 5'd8) begin
      errors++; $display("FAIL rc_resp: got v=%b data=%h idx=%0d required 1 ff 8", rsp_valid, rsp_rd_data, rsp_rd_idx);
    end
    tick();
  endtask

  task automatic test_csrrw_rd0();
    set_req(2'b01, 1'b0, 12'h341, 32'h0000A5A5, 5'd2, 5'd0);
    tick(); req_valid = 1'b0;
    checks++; if (csr_rd_en !== 1'b0 || csr_wr_en !== 1'b1 || csr_wr_data !== 32'h0000A5A5) begin
      errors++; $display("FAIL rw0_write: got rd_en=%b wr_en=%b data=%h required 0 1 a5a5", csr_rd_en, csr_wr_en, csr_wr_data);
    end
    csr_wr_ack = 1'b1;
    tick(); csr_wr_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h0) begin errors++; $display("FAIL rw0_resp: got v=%b data=%h required 1 0", rsp_valid, rsp_rd_data); end
    tick();
  endtask

  task automatic test_illegal_op();
    set_req(2'b00, 1'b0, 12'h340, 32'h1, 5'd1, 5'd4);
    tick(); req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || csr_rd_en !== 1'b0 || csr_wr_en !== 1'b0) begin
      errors++; $display("FAIL ill_resp: got v=%b ill=%b rd=%b wr=%b required 1 1 0 0", rsp_valid, rsp_illegal, csr_rd_en, csr_wr_en);
    end
    checks++; if (rsp_rd_data !== 32'h0) begin errors++; $display("FAIL ill_data: got %h required 0", rsp_rd_data); end
    tick();
    checks++; if (req_ready !== 1'b1 || rsp_illegal !== 1'b0) begin errors++; $display("FAIL ill_idle: got ready=%b ill=%b required 1 0", req_ready, rsp_illegal); end
  endtask

  task automatic test_ro_csr();
    set_req(2'b01, 1'b0, 12'hC00, 32'h00001234, 5'd1, 5'd1);
    tick(); req_valid = 1'b0;
`ifdef CSR_RO_CHECK_EN
    checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_rd_data !== 32'h0 || csr_rd_en !== 1'b0 || csr_wr_en !== 1'b0) begin
      errors++; $display("FAIL ro_reject: got v=%b ill=%b data=%h rd=%b wr=%b required 1 1 0 0 0", rsp_valid, rsp_illegal, rsp_rd_data, csr_rd_en, csr_wr_en);
    end
    tick();
`else
    checks++; if (csr_rd_en !== 1'b1 || csr_rd_addr !== 12'hC00) begin errors++; $display("FAIL ro_read: got en=%b addr=%h required 1 c00", csr_rd_en, csr_rd_addr); end
    csr_rd_data = 32'h00000055; csr_rd_valid = 1'b1;
    tick(); csr_rd_valid = 1'b0;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_addr !== 12'hC00 || csr_wr_data !== 32'h1234) begin
      errors++; $display("FAIL ro_write: got en=%b addr=%h data=%h required 1 c00 1234", csr_wr_en, csr_wr_addr, csr_wr_data);
    end
    csr_wr_ack = 1'b1;
    tick(); csr_wr_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b0 || rsp_rd_data !== 32'h55) begin
      errors++; $display("FAIL ro_resp: got v=%b ill=%b data=%h required 1 0 55", rsp_valid, rsp_illegal, rsp_rd_data);
    end
    tick();
`endif
  endtask

  task automatic test_reset_in_write();
    // CSRRWI rd=0: straight to WRITE with immediate operand
    set_req(2'b01, 1'b1, 12'h342, 32'hFFFFFFFF, 5'd7, 5'd0);
    tick(); req_valid = 1'b0;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_data !== 32'h7) begin errors++; $display("FAIL rstw_write: got en=%b data=%h required 1 7", csr_wr_en, csr_wr_data); end
    tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    checks++; if (csr_wr_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_abort: got wr=%b ready=%b v=%b required 0 1 0", csr_wr_en, req_ready, rsp_valid);
    end
    tick();
    checks++; if (csr_wr_en !== 1'b0) begin errors++; $display("FAIL rstw_no_write: got %b required 0", csr_wr_en); end
  endtask

  task automatic test_resp_stall();
    // CSRRSI zimm=0x11 on a CSR holding 0x100 -> writes 0x111
    set_req(2'b10, 1'b1, 12'h305, 32'h0, 5'h11, 5'd9);
    tick(); req_valid = 1'b0;
    csr_rd_data = 32'h00000100; csr_rd_valid = 1'b1;
    tick(); csr_rd_valid = 1'b0;
    checks++; if (csr_wr_data !== 32'h111) begin errors++; $display("FAIL stall_wdata: got %h required 111", csr_wr_data); end
    rsp_ready = 1'b0; csr_wr_ack = 1'b1;
    tick(); csr_wr_ack = 1'b0;
    csr_rd_data = 32'hBAD0BAD0;
    // A second request waits while the response is stalled.
    set_req(2'b01, 1'b0, 12'h343, 32'h00C0FFEE, 5'd1, 5'd0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h100 || rsp_rd_idx !== 5'd9 || rsp_illegal !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d: got v=%b data=%h idx=%0d ill=%b ready=%b required 1 100 9 0 0", i, rsp_valid, rsp_rd_data, rsp_rd_idx, rsp_illegal, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got ready=%b v=%b required 1 0", req_ready, rsp_valid); end
    tick(); req_valid = 1'b0;
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_addr !== 12'h343 || csr_wr_data !== 32'h00C0FFEE) begin
      errors++; $display("FAIL b2b_write: got en=%b addr=%h data=%h required 1 343 c0ffee", csr_wr_en, csr_wr_addr, csr_wr_data);
    end
    csr_wr_ack = 1'b1;
    tick(); csr_wr_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h0) begin errors++; $display("FAIL b2b_resp: got v=%b data=%h required 1 0", rsp_valid, rsp_rd_data); end
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_imm = 1'b0; req_addr = 12'h0;
    req_rs1_val = 32'h0; req_zimm = 5'd0; req_rd_idx = 5'd0;
    csr_rd_data = 32'h0; csr_rd_valid = 1'b0; csr_wr_ack = 1'b0; rsp_ready = 1'b1;
    test_reset();
    test_csrrw();
    test_csrrs_noread_write();
    test_csrrc_delayed();
    test_csrrw_rd0();
    test_illegal_op();
    test_ro_csr();
    test_reset_in_write();
    test_resp_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
